pmu_counter_bank: RTL and testbench
===================================

PMU_COUNTER_BANK -- requirements
Module: pmu_counter_bank

Interface
REQ-001 SHALL have parameter N_COUNTERS, default 23, number of 64-bit event counters; legal range 1..62.
REQ-002 SHALL have port clk_i  in  1  core clock; single clock domain for the whole block.
REQ-003 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port events_i  in  N_COUNTERS  per-counter increment strobes, one per cycle, in the clk_i domain.
REQ-005 SHALL have port counter_read_enable  in  1  read request level from the AXI side (asynchronous to clk_i).
REQ-006 SHALL have port counter_read_address  in  8  read word address, stable while counter_read_enable is high.
REQ-007 SHALL have port counter_read_valid  out  1  read acknowledge level.
REQ-008 SHALL have port counter_read_data  out  64  read data, stable while counter_read_valid is high.
REQ-009 SHALL have port counter_write_enable  in  1  write request level (asynchronous to clk_i).
REQ-010 SHALL have port counter_write_address  in  8  write word address, stable while counter_write_enable is high.
REQ-011 SHALL have port counter_write_data  in  64  write data, stable while counter_write_enable is high.
REQ-012 SHALL have port counter_write_valid  out  1  write acknowledge level.

Function
REQ-013 SHALL map address 0 to CONFIG: bit0 global enable (R/W), bit1 clear-all (write-only, reads 0), bits 63:2 read 0.
REQ-014 SHALL map address i+1 (i = 0..N_COUNTERS-1) to counter i, 64-bit R/W.
REQ-015 SHALL return 0 on reads of unmapped addresses, ignore writes to them, and still acknowledge both.
REQ-016 SHALL increment counter i by 1 on each cycle where events_i[i]=1 and CONFIG.bit0=1; when bit0=0, counters hold.
REQ-017 SHALL wrap a counter from 2^64-1 to 0.
REQ-018 SHALL pass counter_read_enable and counter_write_enable each through a 2-flop synchronizer before use.
REQ-019 SHALL implement a four-phase handshake per channel: synced enable rising while valid=0 -> perform access and set valid on the next edge; valid held until synced enable is 0, then cleared on the next edge.
REQ-020 SHALL assert valid on the 3rd clk_i rising edge after the enable rises (2 sync stages + 1 access cycle).
REQ-021 SHALL sample read data once, at the access cycle, and hold counter_read_data constant until the next read access.
REQ-022 SHALL perform exactly one write per handshake, regardless of how long the enable is held.
REQ-023 SHALL let a register write take priority over a same-cycle event increment of the same counter.
REQ-024 SHALL let clear-all zero all counters in its write cycle, taking priority over same-cycle events; the bit0 value is written in the same access.
REQ-025 SHALL serve read and write channels independently; a same-cycle read and write to the same counter returns the pre-write value.

Reset
REQ-026 SHALL, on rstn_i low, immediately set all counters to 0, CONFIG.bit0 to 0, counter_read_valid to 0, counter_read_data to 0, counter_write_valid to 0, and the synchronizer flops to 0.
REQ-027 SHALL abandon any in-flight handshake on reset; after release, a still-high enable is treated as a new request.

Configuration
REQ-028 SHALL, when PMU_OVERFLOW_STATUS_EN is defined, map address N_COUNTERS+1 to OVF_STATUS: bit i is set sticky when counter i wraps, write-1-to-clear; if a set and a clear hit the same bit in one cycle, the set wins.
REQ-029 SHALL, when PMU_OVERFLOW_STATUS_EN is undefined, include no overflow logic and treat address N_COUNTERS+1 as unmapped.

Verification
REQ-030 Reset then write CONFIG=0x1 and pulse events_i[0] 5 cycles -> read address 1 returns 5; counter_read_valid rises on the 3rd edge after enable.
REQ-031 Write counter 2 (address 3) = 0xFFFF_FFFF_FFFF_FFFF, enable counting, 1 event -> read address 3 returns 0; with PMU_OVERFLOW_STATUS_EN, OVF_STATUS bit2=1, and writing 0x4 clears it.
REQ-032 Write CONFIG=0x3 while events_i are active -> all counters read 0, CONFIG reads 0x1.
REQ-033 Write counter 0 = 100 in the same cycle as events_i[0]=1 -> counter 0 reads 100.
REQ-034 Hold counter_write_enable high 20 cycles with CONFIG=0x0 -> exactly one write occurs; counter_write_valid stays high until 3 edges after enable falls... cleared within 3 edges; a read of address 0xFF returns 0 and is acknowledged.
REQ-035 Assert rstn_i low while counter_read_valid=1 -> valid drops immediately, counters read 0 after release.

Source files
------------

// File: rtl/pmu_counter_bank.sv
// Bank of N_COUNTERS 64-bit event counters with a CONFIG word, accessed over
// independent four-phase read/write handshakes. Optional overflow status via PMU_OVERFLOW_STATUS_EN.
module pmu_counter_bank #(
    parameter int N_COUNTERS = 23
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [N_COUNTERS-1:0] events_i,
    input  logic                  counter_read_enable,
    input  logic [7:0]            counter_read_address,
    output logic                  counter_read_valid,
    output logic [63:0]           counter_read_data,
    input  logic                  counter_write_enable,
    input  logic [7:0]            counter_write_address,
    input  logic [63:0]           counter_write_data,
    output logic                  counter_write_valid
);

    localparam logic [7:0] CONFIG_ADDR = 8'd0;
`ifdef PMU_OVERFLOW_STATUS_EN
    localparam logic [7:0] OVF_ADDR = 8'(N_COUNTERS + 1);
`endif

    logic [1:0]            rd_sync;
    logic [1:0]            wr_sync;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  cfg_en;
    logic                  clr_all;
    logic [N_COUNTERS-1:0] cnt_wr_sel;
    logic [N_COUNTERS-1:0] inc_en;
    logic [63:0]           cnt [N_COUNTERS];
    logic [63:0]           rd_word;
`ifdef PMU_OVERFLOW_STATUS_EN
    logic [N_COUNTERS-1:0] ovf_status;
    logic [N_COUNTERS-1:0] wrap;
    logic                  ovf_wr;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_sync <= 2'b00;
            wr_sync <= 2'b00;
        end else begin
            rd_sync <= {rd_sync[0], counter_read_enable};
            wr_sync <= {wr_sync[0], counter_write_enable};
        end
    end

    // An access fires once per handshake: only while the acknowledge is still low.
    assign rd_fire = rd_sync[1] & ~counter_read_valid;
    assign wr_fire = wr_sync[1] & ~counter_write_valid;
    assign clr_all = wr_fire && (counter_write_address == CONFIG_ADDR) && counter_write_data[1];

    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        cnt_wr_sel = '0;
        inc_en     = '0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            cnt_wr_sel[i] = wr_fire && (counter_write_address == 8'(i + 1));
            inc_en[i]     = cfg_en && events_i[i];
        end
    end

    always_comb begin
        rd_word = '0;
        if (counter_read_address == CONFIG_ADDR)
            rd_word = {63'd0, cfg_en};
        for (int i = 0; i < N_COUNTERS; i++) begin
            if (counter_read_address == 8'(i + 1))
                rd_word = cnt[i];
        end
`ifdef PMU_OVERFLOW_STATUS_EN
        if (counter_read_address == OVF_ADDR)
            rd_word = 64'(ovf_status);
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cfg_en <= 1'b0;
        end else if (wr_fire && (counter_write_address == CONFIG_ADDR)) begin
            cfg_en <= counter_write_data[0];
        end
    end

    // NOTE: the counter array is reset explicitly; it is architectural state, not a RAM.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N_COUNTERS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_COUNTERS; i++) begin
                if (clr_all)
                    cnt[i] <= '0;
                else if (cnt_wr_sel[i])
                    cnt[i] <= counter_write_data;
                else if (inc_en[i])
                    cnt[i] <= cnt[i] + 64'd1;
            end
        end
    end

`ifdef PMU_OVERFLOW_STATUS_EN
    assign ovf_wr = wr_fire && (counter_write_address == OVF_ADDR);

    always_comb begin
        wrap = '0;
        for (int i = 0; i < N_COUNTERS; i++)
            wrap[i] = inc_en[i] && !cnt_wr_sel[i] && !clr_all && (cnt[i] == '1);
    end

    // Sticky set beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_status <= '0;
        end else begin
            ovf_status <= wrap | (ovf_status & ~({N_COUNTERS{ovf_wr}} & counter_write_data[N_COUNTERS-1:0]));
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            counter_read_valid <= 1'b0;
            counter_read_data  <= '0;
        end else if (rd_fire) begin
            counter_read_valid <= 1'b1;
            counter_read_data  <= rd_word;
        end else if (counter_read_valid && !rd_sync[1]) begin
            counter_read_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            counter_write_valid <= 1'b0;
        end else if (wr_fire) begin
            counter_write_valid <= 1'b1;
        end else if (counter_write_valid && !wr_sync[1]) begin
            counter_write_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Directed self-checking bench for pmu_counter_bank; define PMU_OVERFLOW_STATUS_EN
// for both RTL and bench to exercise the overflow status register.
module tb_pmu_counter_bank;

    localparam int N = 23;

    logic          clk;
    logic          rstn;
    logic [N-1:0]  events;
    logic          re;
    logic [7:0]    ra;
    logic          rv;
    logic [63:0]   rd;
    logic          we;
    logic [7:0]    wa;
    logic [63:0]   wd;
    logic          wv;

    int n_checks = 0;
    int n_errors = 0;

    pmu_counter_bank #(.N_COUNTERS(N)) dut (
        .clk_i                 (clk),
        .rstn_i                (rstn),
        .events_i              (events),
        .counter_read_enable   (re),
        .counter_read_address  (ra),
        .counter_read_valid    (rv),
        .counter_read_data     (rd),
        .counter_write_enable  (we),
        .counter_write_address (wa),
        .counter_write_data    (wd),
        .counter_write_valid   (wv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [7:0] a, output logic [63:0] d);
        int n;
        @(negedge clk);
        ra = a;
        re = 1'b1;
        n  = 0;
        while (!rv && n < 8) begin
            @(posedge clk); #1; n++;
        end
        check("rd_ack_edges", 64'(n), 64'd3);
        d = rd;
        @(negedge clk);
        re = 1'b0;
        n  = 0;
        while (rv && n < 8) begin
            @(posedge clk); #1; n++;
        end
        check("rd_clr_edges", 64'(n), 64'd3);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [63:0] d, input bit kill_ev);
        int n;
        @(negedge clk);
        wa = a;
        wd = d;
        we = 1'b1;
        n  = 0;
        while (!wv && n < 8) begin
            @(posedge clk); #1; n++;
        end
        if (kill_ev) events = '0;
        check("wr_ack_edges", 64'(n), 64'd3);
        @(negedge clk);
        we = 1'b0;
        n  = 0;
        while (wv && n < 8) begin
            @(posedge clk); #1; n++;
        end
        check("wr_clr_edges", 64'(n), 64'd3);
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [63:0] exp);
        logic [63:0] d;
        do_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        int n;
        rstn   = 1'b0;
        events = '0;
        re     = 1'b0;
        ra     = '0;
        we     = 1'b0;
        wa     = '0;
        wd     = '0;
        #1;
        check("rst_rd_valid", 64'(rv), 64'd0);
        check("rst_rd_data", rd, 64'd0);
        check("rst_wr_valid", 64'(wv), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        read_check("cfg_after_rst", 8'd0, 64'd0);

        // Enable counting, five events on counter 0.
        do_write(8'd0, 64'h1, 1'b0);
        @(negedge clk);
        events[0] = 1'b1;
        repeat (5) @(negedge clk);
        events = '0;
        read_check("cnt0_five", 8'd1, 64'd5);
        read_check("cfg_enabled", 8'd0, 64'd1);

        // Wrap of counter 2.
        do_write(8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        read_check("cnt2_all_ones", 8'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        events[2] = 1'b1;
        @(negedge clk);
        events = '0;
        read_check("cnt2_wrapped", 8'd3, 64'd0);
        read_check("cnt1_untouched", 8'd2, 64'd0);
        read_check("cnt0_held", 8'd1, 64'd5);
`ifdef PMU_OVERFLOW_STATUS_EN
        read_check("ovf_bit2_set", 8'(N + 1), 64'h4);
        do_write(8'(N + 1), 64'h4, 1'b0);
        read_check("ovf_bit2_cleared", 8'(N + 1), 64'h0);
`else
        read_check("ovf_addr_unmapped", 8'(N + 1), 64'h0);
`endif

        // Last counter mapping.
        @(negedge clk);
        events[N-1] = 1'b1;
        repeat (2) @(negedge clk);
        events = '0;
        read_check("cnt_last_two", 8'(N), 64'd2);

        // Clear-all while every event line is active; bit0 written in the same access.
        @(negedge clk);
        events = '1;
        do_write(8'd0, 64'h3, 1'b1);
        read_check("clr_cnt0", 8'd1, 64'd0);
        read_check("clr_cnt2", 8'd3, 64'd0);
        read_check("clr_cnt_last", 8'(N), 64'd0);
        read_check("clr_cfg_reads_1", 8'd0, 64'd1);

        // Register write beats a same-cycle increment.
        @(negedge clk);
        events[0] = 1'b1;
        do_write(8'd1, 64'd100, 1'b1);
        read_check("wr_beats_event", 8'd1, 64'd100);

        // Enable held 20 cycles with counter 1 counting: one write at edge 3, then 17 increments.
        @(negedge clk);
        events[1] = 1'b1;
        wa = 8'd2;
        wd = 64'd50;
        we = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 2) check("hold_no_ack_edge2", 64'(wv), 64'd0);
            if (c == 3) check("hold_ack_edge3", 64'(wv), 64'd1);
        end
        check("hold_ack_edge20", 64'(wv), 64'd1);
        @(negedge clk);
        events = '0;
        we     = 1'b0;
        read_check("hold_single_write", 8'd2, 64'd67);

        // Counting disabled: held write to counter 2, events must not count.
        do_write(8'd0, 64'h0, 1'b0);
        read_check("cfg_disabled", 8'd0, 64'd0);
        @(negedge clk);
        events = '1;
        wa = 8'd3;
        wd = 64'h1234;
        we = 1'b1;
        repeat (20) @(negedge clk);
        check("hold2_ack_high", 64'(wv), 64'd1);
        we = 1'b0;
        n  = 0;
        while (wv && n < 8) begin
            @(posedge clk); #1; n++;
        end
        check("hold2_clr_edges", 64'(n), 64'd3);
        events = '0;
        read_check("hold2_value", 8'd3, 64'h1234);
        read_check("disabled_cnt0_held", 8'd1, 64'd100);

        // Unmapped addresses: read returns 0, write ignored, both acknowledged.
        read_check("unmapped_rd_ff", 8'hFF, 64'd0);
        do_write(8'hF0, 64'hDEAD, 1'b0);
        read_check("unmapped_wr_ignored", 8'hF0, 64'd0);

        // Same-cycle read and write of counter 0 returns the pre-write value.
        @(negedge clk);
        ra = 8'd1;
        wa = 8'd1;
        wd = 64'd200;
        re = 1'b1;
        we = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rw_rd_ack", 64'(rv), 64'd1);
        check("rw_wr_ack", 64'(wv), 64'd1);
        check("rw_pre_write_data", rd, 64'd100);
        @(negedge clk);
        re = 1'b0;
        we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rw_rd_clr", 64'(rv), 64'd0);
        check("rw_wr_clr", 64'(wv), 64'd0);
        read_check("rw_post_write", 8'd1, 64'd200);

        // Reset during an acknowledged read; held enable restarts after release.
        @(negedge clk);
        ra = 8'd3;
        re = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_ack", 64'(rv), 64'd1);
        check("rst_mid_data", rd, 64'h1234);
        rstn = 1'b0;
        #1;
        check("rst_valid_drops", 64'(rv), 64'd0);
        check("rst_data_zero", rd, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        while (!rv && n < 8) begin
            @(posedge clk); #1; n++;
        end
        check("rst_rerequest_edges", 64'(n), 64'd3);
        check("rst_rerequest_data", rd, 64'd0);
        @(negedge clk);
        re = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rerequest_clr", 64'(rv), 64'd0);
        read_check("post_rst_cnt0", 8'd1, 64'd0);
        read_check("post_rst_cfg", 8'd0, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
